// File: rtl/row_clear_ctrl_pkg.sv
// Board geometry and line-clear sequencer state encoding, shared by the
// clear controller and gamelogic so both agree on board shape.
package row_clear_ctrl_pkg;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int XW   = 4;
  localparam int YW   = 5;
  localparam int CW   = 3;

  localparam logic [XW-1:0] LAST_COL  = XW'(COLS - 1);
  localparam logic [YW-1:0] LAST_ROW  = YW'(ROWS - 1);
  localparam logic [CW-1:0] LINES_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SHIFT,
    CLR_TOP,
    DONE
  } state_t;

  // Line counter sticks at its maximum instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == LINES_MAX) ? v : v + CW'(1);
  endfunction

endpackage

// File: rtl/row_clear_ctrl.sv
// Line-clear sequencer: scans the board bottom-up, drops everything above
// each full row by one cell per cycle, blanks row 0 and rescans that row.
module row_clear_ctrl
  import row_clear_ctrl_pkg::*;
(
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          start,
  input  logic          board_rdata,
  output logic [XW-1:0] board_rx,
  output logic [YW-1:0] board_ry,
  output logic          board_we,
  output logic [XW-1:0] board_wx,
  output logic [YW-1:0] board_wy,
  output logic          board_wdata,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] lines_cleared,
  output state_t        state_dbg
);

  // Handshake: start is a request accepted only while busy=0; once accepted,
  // busy stays high until the cycle after the single-cycle done pulse, and
  // any start seen while busy=1 is dropped, never queued.

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] scan_y;
  logic [YW-1:0] shift_y;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      x             <= '0;
      scan_y        <= LAST_ROW;
      shift_y       <= '0;
      lines_cleared <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lines_cleared <= '0;
            scan_y        <= LAST_ROW;
            x             <= '0;
            state         <= SCAN;
          end
        end

        SCAN: begin
          if (!board_rdata) begin
            // First empty cell ends the row early.
            if (scan_y == '0) begin
              state <= DONE;
            end else begin
              scan_y <= scan_y - YW'(1);
              x      <= '0;
            end
          end else if (x != LAST_COL) begin
            x <= x + XW'(1);
          end else begin
            lines_cleared <= sat_inc(lines_cleared);
            shift_y       <= scan_y;
            x             <= '0;
            state         <= (scan_y == '0) ? CLR_TOP : SHIFT;
          end
        end

        SHIFT: begin
          if (x != LAST_COL) begin
            x <= x + XW'(1);
          end else begin
            x <= '0;
            if (shift_y == YW'(1)) begin
              state <= CLR_TOP;
            end else begin
              shift_y <= shift_y - YW'(1);
            end
          end
        end

        CLR_TOP: begin
          // scan_y is left alone so the dropped-in row gets rescanned.
          if (x != LAST_COL) begin
            x <= x + XW'(1);
          end else begin
            x     <= '0;
            state <= SCAN;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    board_rx    = '0;
    board_ry    = '0;
    board_we    = 1'b0;
    board_wx    = '0;
    board_wy    = '0;
    board_wdata = 1'b0;
    busy        = (state != IDLE);
    done        = (state == DONE);
    case (state)
      SCAN: begin
        board_rx = x;
        board_ry = scan_y;
      end
      SHIFT: begin
        // Read the cell above and write it here on the same edge.
        board_rx    = x;
        board_ry    = shift_y - YW'(1);
        board_we    = 1'b1;
        board_wx    = x;
        board_wy    = shift_y;
        board_wdata = board_rdata;
      end
      CLR_TOP: begin
        board_we    = 1'b1;
        board_wx    = x;
        board_wy    = '0;
        board_wdata = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign state_dbg = state;

endmodule
